// File: rtl/neck_detect_ctrl_if.sv
// Sample/result bundle between kalman_filter, neck_detect_ctrl and the power_switch pad.
// The slave modport is the detector's view; the master modport is the upstream/driver view.
interface neck_detect_ctrl_if #(parameter int DW = 13);
  logic                 en;
  logic                 din_valid;
  logic signed [DW-1:0] din;
  logic signed [DW-1:0] d1_out;
  logic signed [DW-1:0] d2_out;
  logic                 dout_valid;
  logic                 power_switch;
  logic                 neck_flag;
  logic [2:0]           state;
  logic [15:0]          neck_cnt;

  modport master (
    output en, din_valid, din,
    input  d1_out, d2_out, dout_valid, power_switch, neck_flag, state, neck_cnt
  );
  modport slave (
    input  en, din_valid, din,
    output d1_out, d2_out, dout_valid, power_switch, neck_flag, state, neck_cnt
  );
endinterface

// File: rtl/neck_detect_ctrl.sv
// Neck detector: 1st/2nd differences of the filtered weld voltage, N-sample confirmation,
// cut / hold-off sequencing of the welder power switch. Define NECK_STAT_EN to build the neck counter.
module neck_detect_ctrl #(
  parameter int                   DW             = 13,
  parameter logic signed [DW-1:0] THR1           = DW'(20),
  parameter logic signed [DW-1:0] THR2           = DW'(8),
  parameter int                   CONFIRM_N      = 3,
  parameter int                   OFF_CYCLES     = 2000,
  parameter int                   HOLDOFF_CYCLES = 10000,
  parameter int                   CW             = 16
) (
  input logic           clk,
  input logic           rst_n,
  neck_detect_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    CUT     = 3'd2,
    HOLDOFF = 3'd3
  } state_t;

  localparam logic [CW-1:0] OFF_LD  = CW'(OFF_CYCLES);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLDOFF_CYCLES);
  localparam logic [3:0]    CONF_N  = 4'(CONFIRM_N);

  // Clamp a DW+1 bit difference back into DW bits.
  function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] v);
    if (v[DW] != v[DW-1])
      return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return v[DW-1:0];
  endfunction

  logic signed [DW-1:0] x1, d1_prev, d1_q, d2_q, d1_nxt, d2_nxt;
  logic signed [DW:0]   d1_wide, d2_wide;
  logic [1:0]           prime;
  logic                 primed_q, dv_q, qual;

  state_t          st, st_nxt;
  logic [3:0]      conf, conf_nxt;
  logic [CW-1:0]   tmr, tmr_nxt;
  logic            flag_q, flag_nxt, ps_q;

  assign d1_wide = {bus.din[DW-1], bus.din} - {x1[DW-1], x1};
  assign d1_nxt  = sat(d1_wide);
  assign d2_wide = {d1_nxt[DW-1], d1_nxt} - {d1_prev[DW-1], d1_prev};
  assign d2_nxt  = sat(d2_wide);

  // Difference pipeline runs regardless of en or FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1       <= '0;
      d1_prev  <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      prime    <= '0;
      primed_q <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      dv_q <= bus.din_valid;
      if (bus.din_valid) begin
        x1       <= bus.din;
        d1_prev  <= d1_nxt;
        d1_q     <= d1_nxt;
        d2_q     <= d2_nxt;
        primed_q <= (prime == 2'd2);
        if (prime != 2'd2) prime <= prime + 2'd1;
      end
    end
  end

  assign qual = dv_q && primed_q && (d1_q >= THR1) && (d2_q >= THR2);

  always_comb begin
    st_nxt   = st;
    conf_nxt = conf;
    tmr_nxt  = tmr;
    flag_nxt = 1'b0;
    case (st)
      IDLE: begin
        conf_nxt = '0;
        if (bus.en) st_nxt = ARM;
      end
      ARM: begin
        if (!bus.en) begin
          st_nxt   = IDLE;
          conf_nxt = '0;
        end else if (qual) begin
          if (conf + 4'd1 == CONF_N) begin
            st_nxt   = CUT;
            tmr_nxt  = OFF_LD;
            conf_nxt = '0;
            flag_nxt = 1'b1;
          end else begin
            conf_nxt = conf + 4'd1;
          end
        end else if (dv_q) begin
          conf_nxt = '0;
        end
      end
      CUT: begin
        if (tmr == CW'(1)) begin
          st_nxt  = HOLDOFF;
          tmr_nxt = HOLD_LD;
        end else begin
          tmr_nxt = tmr - CW'(1);
        end
      end
      HOLDOFF: begin
        conf_nxt = '0;
        if (tmr == CW'(1)) st_nxt = bus.en ? ARM : IDLE;
        else               tmr_nxt = tmr - CW'(1);
      end
      default: begin
        st_nxt   = IDLE;
        conf_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      conf   <= '0;
      tmr    <= '0;
      flag_q <= 1'b0;
      ps_q   <= 1'b1;
    end else begin
      st     <= st_nxt;
      conf   <= conf_nxt;
      tmr    <= tmr_nxt;
      flag_q <= flag_nxt;
      ps_q   <= (st_nxt != CUT);
    end
  end

`ifdef NECK_STAT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= '0;
    else if (flag_q && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
  assign bus.neck_cnt = cnt;
`else
  assign bus.neck_cnt = '0;
`endif

  assign bus.d1_out       = d1_q;
  assign bus.d2_out       = d2_q;
  assign bus.dout_valid   = dv_q;
  assign bus.power_switch = ps_q;
  assign bus.neck_flag    = flag_q;
  assign bus.state        = st;

endmodule

// File: tb/tb_neck_detect_ctrl.sv
// Directed scenarios plus a random sample stream, every cycle compared to a behavioural model
// that tracks sample history and state dwell times in clock counts.
module tb_neck_detect_ctrl;
  localparam int DW = 13, THR1 = 20, THR2 = 8, CONF_N = 3, OFF = 2000, HOLD = 10000;
`ifdef NECK_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  neck_detect_ctrl_if #(.DW(DW)) bus();
  neck_detect_ctrl #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0, n_bad = 0;
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Behavioural model state.
  int m_x1, m_d1p, m_nsmp, m_d1o, m_d2o, m_st, m_conf, m_cnt;
  longint cyc, m_t0;
  bit m_dv, m_pr, m_ps, m_flag;

  function automatic int sat(input int v);
    int hi, lo;
    hi = (1 << (DW - 1)) - 1;
    lo = -(1 << (DW - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic longint pack(input int d1, input int d2, input bit dv, input bit ps,
                                  input bit fl, input int st, input int cnt);
    logic [47:0] p;
    p = {DW'(d1), DW'(d2), dv, ps, fl, 3'(st), 16'(cnt)};
    return longint'(p);
  endfunction

  task automatic model_reset();
    m_x1 = 0; m_d1p = 0; m_nsmp = 0; m_d1o = 0; m_d2o = 0;
    m_st = 0; m_conf = 0; m_cnt = 0; m_t0 = 0;
    m_dv = 0; m_pr = 0; m_ps = 1; m_flag = 0;
  endtask

  task automatic model_step();
    bit qual, f;
    int d1, d2;
    cyc++;
    qual = m_dv && m_pr && m_d1o >= THR1 && m_d2o >= THR2;
    f = 0;
    if (STAT && m_flag && m_cnt < 65535) m_cnt++;
    case (m_st)
      0: if (bus.en) begin m_st = 1; m_conf = 0; end
      1: begin
        if (!bus.en) m_st = 0;
        else if (qual) begin
          if (m_conf + 1 == CONF_N) begin m_st = 2; m_t0 = cyc; f = 1; m_conf = 0; end
          else m_conf++;
        end else if (m_dv) m_conf = 0;
      end
      2: if (cyc - m_t0 == OFF) begin m_st = 3; m_t0 = cyc; end
      default: if (cyc - m_t0 == HOLD) begin m_st = bus.en ? 1 : 0; m_conf = 0; end
    endcase
    m_flag = f;
    m_ps = (m_st != 2);
    m_dv = bus.din_valid;
    if (bus.din_valid) begin
      d1 = sat(int'(bus.din) - m_x1);
      d2 = sat(d1 - m_d1p);
      m_d1o = d1; m_d2o = d2;
      m_pr = (m_nsmp >= 2);
      m_x1 = int'(bus.din); m_d1p = d1;
      if (m_nsmp < 2) m_nsmp++;
    end
  endtask

  int n_flag, n_off, n_hold, last_d1, last_d2;
  task automatic clr_cnt();
    n_flag = 0; n_off = 0; n_hold = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
    chk("cyc", pack(int'(bus.d1_out), int'(bus.d2_out), bus.dout_valid, bus.power_switch,
                    bus.neck_flag, int'(bus.state), int'(bus.neck_cnt)),
               pack(m_d1o, m_d2o, m_dv, m_ps, m_flag, m_st, m_cnt));
    if (bus.neck_flag) n_flag++;
    if (!bus.power_switch) n_off++;
    if (bus.state == 3'd3) n_hold++;
    if (bus.dout_valid) begin last_d1 = int'(bus.d1_out); last_d2 = int'(bus.d2_out); end
  endtask

  task automatic send(input int v);
    bus.din = DW'(v);
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    repeat (9) tick();
  endtask

  task automatic wait_state(input int s, input int limit, input string tag);
    int k;
    k = 0;
    while (int'(bus.state) != s && k < limit) begin tick(); k++; end
    chk(tag, int'(bus.state), s);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    clr_cnt();
  endtask

  int ramp[6]   = '{0, 0, 10, 30, 60, 100};
  int broken[8] = '{0, 0, 10, 30, 60, 60, 100, 150};
  int walk;

  initial begin
    cyc = 0;
    model_reset();
    bus.en = 1'b0; bus.din_valid = 1'b0; bus.din = '0;
    do_reset();
    chk("rst_ps", bus.power_switch, 1);
    chk("rst_state", bus.state, 0);
    chk("rst_dv", bus.dout_valid, 0);

    // Ramp and cut, three times back to back
    bus.en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      clr_cnt();
      foreach (ramp[i]) send(ramp[i]);
      if (r == 0) begin
        chk("ramp_d1", last_d1, 40);
        chk("ramp_d2", last_d2, 10);
      end
      wait_state(3, OFF + 100, "ramp_to_hold");
      wait_state(1, HOLD + 100, "ramp_to_arm");
      chk("ramp_flags", n_flag, 1);
      chk("ramp_off_len", n_off, OFF);
      chk("ramp_hold_len", n_hold, HOLD);
    end
    chk("stat_cnt", bus.neck_cnt, STAT ? 3 : 0);

    // Broken run
    do_reset();
    bus.en = 1'b1;
    foreach (broken[i]) send(broken[i]);
    chk("broken_flags", n_flag, 0);
    chk("broken_off", n_off, 0);
    chk("broken_state", bus.state, 1);

    // Saturation
    do_reset();
    bus.en = 1'b0;
    send(-4096); send(4095);
    chk("sat_pos_d1", last_d1, 4095);
    send(4095); send(-4096);
    chk("sat_neg_d1", last_d1, -4096);
    chk("sat_neg_d2", last_d2, -4096);

    // en drop in ARM
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) send(ramp[i]);
    bus.en = 1'b0;
    repeat (2) tick();
    chk("endrop_idle", bus.state, 0);
    send(100);
    chk("endrop_flags", n_flag, 0);
    chk("endrop_off", n_off, 0);

    // en drop during CUT
    do_reset();
    bus.en = 1'b1;
    foreach (ramp[i]) send(ramp[i]);
    bus.en = 1'b0;
    wait_state(3, OFF + 100, "encut_to_hold");
    wait_state(0, HOLD + 100, "encut_to_idle");
    chk("encut_off_len", n_off, OFF);
    chk("encut_hold_len", n_hold, HOLD);

    // Reset mid-CUT
    do_reset();
    bus.en = 1'b1;
    foreach (ramp[i]) send(ramp[i]);
    chk("midcut_in_cut", bus.state, 2);
    repeat (491) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midcut_ps", bus.power_switch, 1);
    chk("midcut_state", bus.state, 0);
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    clr_cnt();
    send(100); send(300); send(600);
    chk("prime_flags", n_flag, 0);
    chk("prime_state", bus.state, 1);

    // Random stream
    do_reset();
    bus.en = 1'b1;
    walk = 0;
    repeat (20000) begin
      bus.din_valid = ($urandom_range(0, 2) == 0);
      walk += int'($urandom_range(0, 45)) - 5;
      if ($urandom_range(0, 31) == 0) walk = int'($urandom_range(0, 8191)) - 4096;
      if (walk > 4095) walk = 4095;
      if (walk < -4096) walk = -4096;
      if ($urandom_range(0, 499) == 0) bus.en = ~bus.en;
      bus.din = DW'(walk);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/neck_detect_ctrl.md
Name: neck_detect_ctrl

Overview:
Parametrised successor to the fixed neck-judge stage.
- Takes filtered weld-voltage samples with a valid strobe.
- Computes first and second differences internally.
- Qualifies neck events against thresholds with N-sample confirmation.
- Sequences the welder power switch through cut and hold-off intervals.
- Sits between kalman_filter and the power_switch pad, on the 100 MHz domain.

Parameters:
DW, 13, signed sample and difference width (bits)
THR1, 20, first-difference threshold (signed, DW bits)
THR2, 8, second-difference threshold (signed, DW bits)
CONFIRM_N, 3, consecutive qualifying samples required (1..15)
OFF_CYCLES, 2000, clk cycles power held off (20 us at 100 MHz)
HOLDOFF_CYCLES, 10000, clk cycles after re-enable during which detection is blanked
CW, 16, timer width; must hold max(OFF_CYCLES, HOLDOFF_CYCLES)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
en  in  1  detection enable
din_valid  in  1  one-cycle strobe, din valid
din  in  DW  signed filtered sample
d1_out  out  DW  registered saturated first difference
d2_out  out  DW  registered saturated second difference
dout_valid  out  1  strobe for d1_out/d2_out
power_switch  out  1  1 = welder powered, 0 = cut
neck_flag  out  1  one-cycle pulse on entry to CUT
state  out  3  FSM state code: IDLE=0, ARM=1, CUT=2, HOLDOFF=3
neck_cnt  out  16  neck event count (see Optional Feature)

Behaviour:
Reset (asynchronous, rst_n=0):
- power_switch=1; all other outputs 0.
- History and prime counter cleared; FSM in IDLE.

Difference pipeline:
- Updated on every din_valid in every state, independent of en.
- d1 = din - x1, computed at DW+1 bits, saturated to DW.
- d2 = d1 - d1_prev, computed at DW+1 bits, saturated to DW.
- Latency: d1_out, d2_out and dout_valid are registered 1 cycle after din_valid.
- Priming: prime counter runs 0..2.
  - d1 is meaningful from the 2nd sample after reset.
  - d2 is meaningful from the 3rd sample after reset.
  - A sample qualifies only when primed == 2.

Qualifying sample:
- dout_valid && d1 >= THR1 && d2 >= THR2 (signed compare on the saturated values).

FSM (one transition per clk):
- IDLE:
  - power_switch=1.
  - en=1 → ARM, with confirm counter cleared.
- ARM:
  - Qualifying sample → confirm counter +1.
  - Non-qualifying valid sample → confirm counter cleared.
  - Cycles with no dout_valid leave the counter unchanged.
  - Counter reaching CONFIRM_N → CUT on the next clk; neck_flag pulses that cycle.
  - en=0 → IDLE; takes priority over a same-cycle qualification.
- CUT:
  - power_switch=0.
  - Timer counts OFF_CYCLES clk, then → HOLDOFF.
  - en is ignored; the cut always completes.
- HOLDOFF:
  - power_switch=1.
  - Samples are ignored for qualification; the confirm counter is held at 0.
  - After HOLDOFF_CYCLES → ARM if en=1, else IDLE.

Output and boundary rules:
- power_switch is registered: it falls on the same clk the FSM enters CUT and rises on entry to HOLDOFF.
- Timers are loaded on state entry and count down to 1; no wrap-around.
- din_valid on consecutive cycles is supported; there is no backpressure.
- Reset mid-CUT immediately restores power_switch=1 and clears history.

Optional Feature:
Macro NECK_STAT_EN.
- Defined: neck_cnt increments on each neck_flag, saturates at 16'hFFFF, and clears only on reset.
- Undefined: neck_cnt is tied to 0 and the counter logic is not built.

Test Plan:
1. Ramp and cut: reset, en=1, samples 0,0,10,30,60,100 (one every 10 clk) → d1 20,30,40 and d2 10,10,10 qualify. neck_flag pulses once after the 100 sample. power_switch=0 for exactly 2000 clk, then 1. state follows 2→3→1 after 10000 clk.
2. Broken run: samples 0,0,10,30,60,60,100,150 → counter resets at the second 60 (d1=0). No CUT occurs; power_switch stays 1.
3. Saturation: din=-4096 then 4095 → d1_out=4095 (raw 8191 saturated). Then 4095, -4096 → d1_out=-4096 and d2_out=-4096.
4. en drop: en=0 after two qualifying samples in ARM → IDLE, no CUT. en=0 during CUT → full 2000-clk cut completes, then HOLDOFF, then IDLE.
5. Reset mid-CUT: assert rst_n=0 at clk 500 of CUT → power_switch=1 asynchronously and state=0. After release, the first two samples never qualify.
6. With NECK_STAT_EN: run scenario 1 three times → neck_cnt=3. Without the macro, neck_cnt stays 0 throughout.
